// File: rtl/pong_pkg.sv
// Shared screen geometry, fixed object positions, colours and game FSM state
// encoding for the Pong pixel renderer.
package pong_pkg;

  localparam int SCREEN_W   = 640;
  localparam int SCREEN_H   = 480;
  localparam int TICK_ROW   = 480;

  localparam int PADDLE_L_X = 16;
  localparam int PADDLE_R_X = 616;

  localparam int SERVE_X    = 316;
  localparam int SERVE_Y    = 236;

  localparam int NET_X_LO   = 318;
  localparam int NET_X_HI   = 321;

  localparam logic [23:0] COL_BLACK    = 24'h000000;
  localparam logic [23:0] COL_BALL     = 24'hFFFFFF;
  localparam logic [23:0] COL_PADDLE_L = 24'h00FF00;
  localparam logic [23:0] COL_PADDLE_R = 24'h0080FF;
  localparam logic [23:0] COL_NET      = 24'h808080;

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_MISS  = 2'd2
  } game_state_e;

  function automatic logic [3:0] bcd_inc(input logic [3:0] v);
    return (v == 4'd9) ? 4'd0 : v + 4'd1;
  endfunction

  // True when p lies in the half-open span [lo, lo+len).
  function automatic logic in_span(input logic [9:0] p, input logic [9:0] lo, input int len);
    return ({1'b0, p} >= {1'b0, lo}) && ({1'b0, p} < ({1'b0, lo} + 11'(len)));
  endfunction

endpackage

// File: rtl/pong_pixel_renderer_btn_sync.sv
// Two-flop synchroniser for asynchronous button inputs; resets to 0 (not pressed).
module btn_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/pong_pixel_renderer.sv
// Two-player Pong renderer behind the VGA timing generator: per-frame game
// update plus a one-pixel registered RGB/sync stage. PONG_AI_EN makes the right paddle track the ball.
//
// state | meaning
// SERVE | ball parked at centre, waiting for a button on a frame tick
// PLAY  | ball moving, bouncing off walls and paddles
// MISS  | ball hidden for MISS_FRAMES frames after a point is scored
module pong_pixel_renderer
  import pong_pkg::*;
#(
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_W     = 8,
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_SPEED = 4,
  parameter int BALL_SPEED   = 2,
  parameter int MISS_FRAMES  = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  input  logic [9:0] x_in,
  input  logic [9:0] y_in,
  input  logic       active_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [3:0] btn_n,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       blank_n_out,
  output logic [3:0] score_l,
  output logic [3:0] score_r
);

  localparam int PADDLE_Y_MAX = SCREEN_H - PADDLE_H;
  localparam int CNT_W        = $clog2(MISS_FRAMES + 1);

  localparam logic signed [10:0] V_POS      = 11'(BALL_SPEED);
  localparam logic signed [10:0] V_NEG      = 11'(-BALL_SPEED);
  localparam logic signed [10:0] Y_BALL_MAX = 11'(SCREEN_H - BALL_SIZE);
  localparam logic signed [10:0] X_BALL_MAX = 11'(SCREEN_W - BALL_SIZE);
  localparam logic signed [10:0] X_L_HIT    = 11'(PADDLE_L_X + PADDLE_W);
  localparam logic signed [10:0] X_R_HIT    = 11'(PADDLE_R_X - BALL_SIZE);
  localparam logic [9:0]         BX_L_BOUNCE = 10'(PADDLE_L_X + PADDLE_W);
  localparam logic [9:0]         BX_R_BOUNCE = 10'(PADDLE_R_X - BALL_SIZE);
  localparam logic [9:0]         PADDLE_Y_RST = 10'(PADDLE_Y_MAX / 2);

  function automatic logic [9:0] paddle_step(input logic [9:0] y, input logic up, input logic down);
    logic [10:0] y_ext;
    y_ext = {1'b0, y};
    paddle_step = y;
    if (up && !down) begin
      paddle_step = (y_ext < 11'(PADDLE_SPEED)) ? 10'd0 : 10'(y_ext - 11'(PADDLE_SPEED));
    end else if (down && !up) begin
      paddle_step = ((y_ext + 11'(PADDLE_SPEED)) > 11'(PADDLE_Y_MAX)) ?
                    10'(PADDLE_Y_MAX) : 10'(y_ext + 11'(PADDLE_SPEED));
    end
  endfunction

  logic [3:0]         btn_pressed;
  logic               frame_tick;
  logic               serve_go;
  logic               r_up, r_dn;

  game_state_e        state_q, state_d;
  logic [9:0]         bx_q, bx_d, by_q, by_d;
  logic signed [10:0] dx_q, dx_d, dy_q, dy_d;
  logic [9:0]         pl_y_q, pl_y_d, pr_y_q, pr_y_d;
  logic [3:0]         score_l_q, score_l_d, score_r_q, score_r_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic signed [10:0] nx, ny, dy_v;
  logic [9:0]         by_v;
  logic               ovl_l, ovl_r;

  logic [23:0]        pix_rgb;
  logic [23:0]        rgb_q;
  logic               hs_q, vs_q, blank_q;

  btn_sync #(.WIDTH(4)) u_btn_sync (
    .clk    (clk),
    .rst    (rst),
    .async_i(~btn_n),
    .sync_o (btn_pressed)
  );

  assign frame_tick = pix_en && (x_in == 10'd0) && (y_in == 10'(TICK_ROW));

`ifdef PONG_AI_EN
  logic [10:0] pad_c, ball_c;
  assign pad_c    = {1'b0, pr_y_q} + 11'(PADDLE_H / 2);
  assign ball_c   = {1'b0, by_q} + 11'(BALL_SIZE / 2);
  assign r_up     = pad_c > (ball_c + 11'(PADDLE_SPEED));
  assign r_dn     = ball_c > (pad_c + 11'(PADDLE_SPEED));
  assign serve_go = btn_pressed[0] | btn_pressed[1];
`else
  assign r_up     = btn_pressed[2];
  assign r_dn     = btn_pressed[3];
  assign serve_go = |btn_pressed;
`endif

  // Wall bounce first; paddle overlap is judged on the post-bounce row.
  always_comb begin
    nx = $signed({1'b0, bx_q}) + dx_q;
    ny = $signed({1'b0, by_q}) + dy_q;
    by_v = ny[9:0];
    dy_v = dy_q;
    if (ny <= 11'sd0) begin
      by_v = 10'd0;
      dy_v = V_POS;
    end else if (ny >= Y_BALL_MAX) begin
      by_v = Y_BALL_MAX[9:0];
      dy_v = V_NEG;
    end
  end

  assign ovl_l = ({1'b0, by_v} < ({1'b0, pl_y_q} + 11'(PADDLE_H))) &&
                 ({1'b0, pl_y_q} < ({1'b0, by_v} + 11'(BALL_SIZE)));
  assign ovl_r = ({1'b0, by_v} < ({1'b0, pr_y_q} + 11'(PADDLE_H))) &&
                 ({1'b0, pr_y_q} < ({1'b0, by_v} + 11'(BALL_SIZE)));

  always_comb begin
    state_d   = state_q;
    bx_d      = bx_q;
    by_d      = by_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    pl_y_d    = pl_y_q;
    pr_y_d    = pr_y_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    cnt_d     = cnt_q;
    if (frame_tick) begin
      pl_y_d = paddle_step(pl_y_q, btn_pressed[0], btn_pressed[1]);
      pr_y_d = paddle_step(pr_y_q, r_up, r_dn);
      unique case (state_q)
        ST_SERVE: begin
          if (serve_go) state_d = ST_PLAY;
        end
        ST_PLAY: begin
          by_d = by_v;
          dy_d = dy_v;
          if ((dx_q < 11'sd0) && (nx <= X_L_HIT) && ovl_l) begin
            bx_d = BX_L_BOUNCE;
            dx_d = V_POS;
          end else if ((dx_q > 11'sd0) && (nx >= X_R_HIT) && ovl_r) begin
            bx_d = BX_R_BOUNCE;
            dx_d = V_NEG;
          end else if (nx < 11'sd0) begin
            score_r_d = bcd_inc(score_r_q);
            state_d   = ST_MISS;
            cnt_d     = '0;
          end else if (nx > X_BALL_MAX) begin
            score_l_d = bcd_inc(score_l_q);
            state_d   = ST_MISS;
            cnt_d     = '0;
          end else begin
            bx_d = nx[9:0];
          end
        end
        ST_MISS: begin
          // dx is left untouched, so it already points at whoever conceded.
          if (cnt_q == CNT_W'(MISS_FRAMES - 1)) begin
            state_d = ST_SERVE;
            bx_d    = 10'(SERVE_X);
            by_d    = 10'(SERVE_Y);
            dy_d    = V_NEG;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = ST_SERVE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_SERVE;
      bx_q      <= 10'(SERVE_X);
      by_q      <= 10'(SERVE_Y);
      dx_q      <= V_NEG;
      dy_q      <= V_NEG;
      pl_y_q    <= PADDLE_Y_RST;
      pr_y_q    <= PADDLE_Y_RST;
      score_l_q <= 4'd0;
      score_r_q <= 4'd0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      bx_q      <= bx_d;
      by_q      <= by_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      pl_y_q    <= pl_y_d;
      pr_y_q    <= pr_y_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    pix_rgb = COL_BLACK;
    if (!active_in) begin
      pix_rgb = COL_BLACK;
    end else if ((state_q != ST_MISS) && in_span(x_in, bx_q, BALL_SIZE) && in_span(y_in, by_q, BALL_SIZE)) begin
      pix_rgb = COL_BALL;
    end else if (in_span(x_in, 10'(PADDLE_L_X), PADDLE_W) && in_span(y_in, pl_y_q, PADDLE_H)) begin
      pix_rgb = COL_PADDLE_L;
    end else if (in_span(x_in, 10'(PADDLE_R_X), PADDLE_W) && in_span(y_in, pr_y_q, PADDLE_H)) begin
      pix_rgb = COL_PADDLE_R;
    end else if ((x_in >= 10'(NET_X_LO)) && (x_in <= 10'(NET_X_HI)) && !y_in[4]) begin
      pix_rgb = COL_NET;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_q   <= COL_BLACK;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
    end else if (pix_en) begin
      rgb_q   <= pix_rgb;
      hs_q    <= hsync_in;
      vs_q    <= vsync_in;
      blank_q <= active_in;
    end
  end

  assign {red, green, blue} = rgb_q;
  assign hsync_out   = hs_q;
  assign vsync_out   = vs_q;
  assign blank_n_out = blank_q;
  assign score_l     = score_l_q;
  assign score_r     = score_r_q;

endmodule
